// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg
//   Shared definitions for the divider arbiter: default sizing constants,
//   the FSM state enum and a small round-robin helper.
//   No ports (package).
package div_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int W_DEF       = 10;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Requester index that follows g, wrapping at n.
  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// div_arbiter_if
//   Bundles the requester-side handshake and the Divider-side bus.
//   Ports: none (interface). Parameters N_REQ, W size the vectors.
//   slave  : the arbiter's view (takes requests, drives the Divider).
//   master : the environment's view (requesters plus the Divider itself).
interface div_arbiter_if
  import div_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [W-1:0]       rsp_q;
  logic               rsp_dvz;
  logic               rsp_ovf;
  logic               rsp_tmo;

  logic               div_start;
  logic [W-1:0]       div_a;
  logic [W-1:0]       div_b;
  logic               div_busy;
  logic               div_valid;
  logic               div_dvz;
  logic               div_ovf;
  logic [W-1:0]       div_q;

  modport slave (
    input  req_valid, req_a, req_b,
    input  div_busy, div_valid, div_dvz, div_ovf, div_q,
    output req_ready, rsp_valid, rsp_q, rsp_dvz, rsp_ovf, rsp_tmo,
    output div_start, div_a, div_b
  );

  modport master (
    output req_valid, req_a, req_b,
    output div_busy, div_valid, div_dvz, div_ovf, div_q,
    input  req_ready, rsp_valid, rsp_q, rsp_dvz, rsp_ovf, rsp_tmo,
    input  div_start, div_a, div_b
  );

endinterface

// File: rtl/div_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: scans req_i upward from ptr_i (mod N)
//   and returns the first requester found.
//   Ports:
//     req_i  [N]   request vector
//     ptr_i  [IW]  index with highest priority this round
//     gnt_o  [N]   one-hot grant (zero when nothing requested)
//     idx_o  [IW]  index of the granted requester
//     any_o        at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx_o = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    any_o = found;
    gnt_o = found ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter
//   Shares one multi-cycle Divider between N_REQ requesters. A request is
//   accepted round-robin, its operands are issued to the Divider, and the
//   result (or a timeout) is returned as a one-cycle pulse to the owner.
//   Ports:
//     clk   rising-edge clock
//     sclr  synchronous active-high clear; abandons any transaction
//     bus   div_arbiter_if.slave: requests/responses and the Divider bus
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a request while the Divider is not busy
//   ISSUE | div_start pulse, operands on div_a/div_b, wait counter clear
//   WAIT  | waiting for div_valid or timeout
//   RESP  | rsp_valid pulse to the owning requester
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF   // must be >= 2
) (
  input logic         clk,
  input logic         sclr,
  div_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ISSUE = ST_ISSUE;
  localparam logic [1:0] WAIT  = ST_WAIT;
  localparam logic [1:0] RESP  = ST_RESP;

  // cnt_q is the number of WAIT cycles already spent. Terminal count is the
  // step onto TIMEOUT-1, which puts RESP exactly TIMEOUT cycles after the
  // div_start cycle and keeps the counter from ever wrapping.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q,   ptr_d;
  logic [IW-1:0]    gidx_q,  gidx_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic [W-1:0]     q_q,     q_d;
  logic             dvz_q,   dvz_d;
  logic             ovf_q,   ovf_d;
  logic             tmo_q,   tmo_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic             accept;
  logic [N_REQ-1:0] resp_oh;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // sclr is folded in so nothing leaks out during the clear cycle itself.
  assign accept = (state_q == IDLE) && arb_any && !bus.div_busy && !sclr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gidx_d  = arb_idx;
          a_d     = bus.req_a[32'(arb_idx) * W +: W];
          b_d     = bus.req_b[32'(arb_idx) * W +: W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.div_valid) begin
          q_d     = bus.div_q;
          dvz_d   = bus.div_dvz;
          ovf_d   = bus.div_ovf;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          q_d     = '0;
          dvz_d   = 1'b0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        ptr_d   = IW'(rr_next(int'(gidx_q), N_REQ));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_oh = N_REQ'(1) << gidx_q;

  assign bus.req_ready = accept ? arb_gnt : '0;
  assign bus.div_start = !sclr && (state_q == ISSUE);
  assign bus.div_a     = sclr ? '0 : a_q;
  assign bus.div_b     = sclr ? '0 : b_q;
  assign bus.rsp_valid = (!sclr && (state_q == RESP)) ? resp_oh : '0;
  assign bus.rsp_q     = sclr ? '0 : q_q;
  assign bus.rsp_dvz   = !sclr && dvz_q;
  assign bus.rsp_ovf   = !sclr && ovf_q;
  assign bus.rsp_tmo   = !sclr && tmo_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
//   Directed scenarios plus a randomized run against a transaction-level
//   reference: round-robin pick, stub-divider result and expected latency.
module tb_div_arbiter;
  import div_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = 10;
  localparam int TMO = 64;

  logic clk = 1'b0;
  logic sclr;
  always #5 clk = ~clk;

  div_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  div_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .sclr (sclr),
    .bus  (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int p_m   = 0;
  int last_g = -1;
  int t_last_rsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stub Divider ----------------
  int          stub_lat   = 12;
  bit          stub_hang  = 1'b0;
  bit          stub_fixed = 1'b0;
  logic [W-1:0] stub_fixed_q = 10'h0A0;
  bit          stub_active = 1'b0;
  int          stub_due    = 0;
  logic [W-1:0] sa = '0, sb = '0;
  bit          busy_force = 1'b0;
  bit          spur_valid = 1'b0;
  logic        stub_v;

  // Stub result {dvz, ovf, q}: plain division, dvz on b==0, ovf when the
  // quotient does not fit in W-1 bits.
  function automatic logic [W+1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    if (b == '0) return {2'b10, {W{1'b0}}};
    q = a / b;
    return {1'b0, (q > W'(511)), q};
  endfunction

  always @(posedge clk) begin
    if (sclr) stub_active <= 1'b0;
    else if (bus.div_start && !stub_hang) begin
      stub_active <= 1'b1;
      stub_due    <= cyc + stub_lat;
      sa          <= bus.div_a;
      sb          <= bus.div_b;
    end else if (stub_active && cyc == stub_due) stub_active <= 1'b0;
  end

  assign stub_v        = stub_active && (cyc == stub_due);
  assign bus.div_valid = stub_v || spur_valid;
  assign bus.div_busy  = busy_force || stub_active;
  assign {bus.div_dvz, bus.div_ovf, bus.div_q} =
    stub_v ? (stub_fixed ? {2'b00, stub_fixed_q} : ref_div(sa, sb)) : {2'b11, 10'h3A5};

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One full transaction from accept to response.
  // mode 0: drop the granted request after accept, 1: hold all, 2: drop all.
  task automatic serve_one(input int mode, input bit b2b);
    int n, g, t_acc, t_st, t_rsp;
    logic [W-1:0] ea, eb;
    logic [W+1:0] er;
    bit hang;
    #1;
    hang = stub_hang;
    n = 0;
    while (bus.req_ready == '0 && n < 300) begin step(); n++; end
    chk("accept_wait", 32'(n < 300), 1);
    if (n >= 300) return;
    t_acc = cyc;
    g = rr_model(bus.req_valid, p_m);
    last_g = g;
    chk("grant", bus.req_ready, 32'(1) << g);
    if (b2b) chk("accept_spacing", t_acc - t_last_rsp, 1);
    ea = bus.req_a[g*W +: W];
    eb = bus.req_b[g*W +: W];
    er = stub_fixed ? {2'b00, stub_fixed_q} : ref_div(ea, eb);
    if (hang) er = '0;
    step();
    if (mode == 0) bus.req_valid[g] = 1'b0;
    else if (mode == 2) bus.req_valid = '0;
    #1;
    chk("div_start", bus.div_start, 1);
    chk("div_a", bus.div_a, ea);
    chk("div_b", bus.div_b, eb);
    chk("ready_after_accept", bus.req_ready, 0);
    t_st = cyc;
    step();
    chk("start_pulse", bus.div_start, 0);
    n = 0;
    while (bus.rsp_valid == '0 && n < TMO + 40) begin step(); n++; end
    chk("rsp_wait", 32'(n < TMO + 40), 1);
    if (n >= TMO + 40) return;
    t_rsp = cyc;
    chk("rsp_valid", bus.rsp_valid, 32'(1) << g);
    chk("rsp_latency", t_rsp - t_st, hang ? TMO : stub_lat + 1);
    chk("rsp_q", bus.rsp_q, er[W-1:0]);
    chk("rsp_flags", {bus.rsp_dvz, bus.rsp_ovf, bus.rsp_tmo}, {er[W+1], er[W], hang});
    step();
    chk("rsp_pulse", bus.rsp_valid, 0);
    chk("rsp_hold", bus.rsp_q, er[W-1:0]);
    t_last_rsp = t_rsp;
    p_m = (g + 1) % N;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit seen;
    sclr = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = W'(100 + 37 * i);
      bus.req_b[i*W +: W] = W'(i + 3);
    end
    step();
    step();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_dvz, bus.rsp_ovf, bus.rsp_tmo, bus.rsp_q}, 0);
    chk("rst_div", {bus.div_start, bus.div_a, bus.div_b}, 0);

    // all four requesting continuously: 0,1,2,3,0
    sclr = 1'b0;
    p_m  = 0;
    for (int k = 0; k < 5; k++) begin
      serve_one((k == 4) ? 2 : 1, k > 0);
      chk("rr_order", last_g, k % N);
    end

    // single request, fixed stub quotient, 12-cycle divider
    bus.req_valid = 4'b0001;
    bus.req_a[0 +: W] = 10'h050;
    bus.req_b[0 +: W] = 10'h020;
    stub_fixed = 1'b1;
    stub_lat = 12;
    serve_one(0, 1);
    chk("fixed_q", bus.rsp_q, 10'h0A0);
    stub_fixed = 1'b0;

    // divide by zero on requester 2
    bus.req_valid = 4'b0100;
    bus.req_a[2*W +: W] = 10'h123;
    bus.req_b[2*W +: W] = 10'h000;
    serve_one(0, 1);
    chk("dvz_flags", {bus.rsp_dvz, bus.rsp_ovf, bus.rsp_tmo}, 3'b100);

    // divider never answers -> timeout, then a normal transaction
    stub_hang = 1'b1;
    bus.req_valid = 4'b1000;
    bus.req_a[3*W +: W] = 10'h3FF;
    bus.req_b[3*W +: W] = 10'h001;
    serve_one(0, 1);
    chk("tmo_flag", bus.rsp_tmo, 1);
    stub_hang = 1'b0;
    bus.req_valid = 4'b0010;
    bus.req_a[1*W +: W] = 10'h0C8;
    bus.req_b[1*W +: W] = 10'h007;
    serve_one(0, 1);
    chk("after_tmo_flag", bus.rsp_tmo, 0);

    // stray div_valid while idle must be ignored
    spur_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      seen = seen | (|bus.rsp_valid);
    end
    spur_valid = 1'b0;
    chk("spurious_valid", seen, 0);

    // divider busy holds off the grant
    busy_force = 1'b1;
    bus.req_valid = 4'b0010;
    #1;
    seen = |bus.req_ready;
    for (int k = 0; k < 6; k++) begin
      step();
      seen = seen | (|bus.req_ready);
    end
    chk("busy_block", seen, 0);
    busy_force = 1'b0;
    #1;
    chk("busy_release", bus.req_ready, 4'b0010);
    serve_one(0, 0);

    // clear during WAIT: no response, outputs zero, pointer back to 0
    bus.req_valid = 4'b0100;
    bus.req_a[2*W +: W] = 10'h155;
    bus.req_b[2*W +: W] = 10'h00B;
    stub_lat = 30;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 50) begin step(); n++; end
    chk("sclr_accept_wait", 32'(n < 50), 1);
    step();
    bus.req_valid = '0;
    step();
    step();
    sclr = 1'b1;
    #1;
    chk("sclr_out_a", {bus.req_ready, bus.rsp_valid, bus.div_start,
                       bus.rsp_dvz, bus.rsp_ovf, bus.rsp_tmo, bus.rsp_q}, 0);
    chk("sclr_out_b", {bus.div_a, bus.div_b}, 0);
    step();
    step();
    sclr = 1'b0;
    stub_lat = 12;
    p_m = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      seen = seen | (|bus.rsp_valid);
    end
    chk("sclr_no_rsp", seen, 0);
    bus.req_valid = '1;
    serve_one(0, 0);
    chk("sclr_first_grant", last_g, 0);

    // randomized traffic
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
          bus.req_valid[i] = 1'b1;
          bus.req_a[i*W +: W] = W'($urandom);
          bus.req_b[i*W +: W] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 40));
        end
      end
      if (bus.req_valid == '0) bus.req_valid[$urandom_range(0, N-1)] = 1'b1;
      stub_lat  = $urandom_range(1, 20);
      stub_hang = ($urandom_range(0, 9) == 0);
      serve_one(0, 1);
    end
    stub_hang = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one Divider.
REQ-002 Parameter W, default 10, operand/quotient width, matching Divider a_in/b_in/q_out.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles to wait for div_valid after div_start.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 sclr  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester operation request.
REQ-007 req_a  in  N_REQ*W  dividends, requester i at bits [i*W +: W].
REQ-008 req_b  in  N_REQ*W  divisors, same packing.
REQ-009 req_ready  out  N_REQ  one-hot accept pulse.
REQ-010 rsp_valid  out  N_REQ  one-hot response pulse to the owning requester.
REQ-011 rsp_q  out  W  quotient, shared by all requesters.
REQ-012 rsp_dvz, rsp_ovf, rsp_tmo  out  1 each  divide-by-zero, overflow and timeout flags, qualified by rsp_valid.
REQ-013 div_start  out  1  start pulse to Divider.
REQ-014 div_a, div_b  out  W each  Divider operands.
REQ-015 div_busy, div_valid, div_dvz, div_ovf  in  1 each  Divider status.
REQ-016 div_q  in  W  Divider quotient.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-018 IDLE: if any req_valid is high and div_busy is 0, the block SHALL grant requester g (round-robin), pulse req_ready[g] for 1 cycle, latch req_a/req_b of g and g itself, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-019 Round-robin: search SHALL start at pointer p and proceed upward mod N_REQ; after RESP, p SHALL become (g+1) mod N_REQ.
REQ-020 ISSUE: div_start SHALL be 1 for exactly 1 cycle, the wait counter SHALL clear, and the FSM SHALL go to WAIT.
REQ-021 div_a/div_b SHALL hold the latched operands from ISSUE until the FSM returns to IDLE.
REQ-022 WAIT: on div_valid=1 the block SHALL capture div_q, div_dvz and div_ovf, set tmo=0, and go to RESP.
REQ-023 WAIT: if the counter reaches TIMEOUT-1 without div_valid, the block SHALL set rsp_tmo=1, rsp_q=0, dvz=ovf=0, and go to RESP; if div_valid arrives in that same cycle, div_valid SHALL win.
REQ-024 RESP: rsp_valid[g] SHALL be 1 for exactly 1 cycle with the captured data, then the FSM SHALL return to IDLE. Responses have no backpressure.
REQ-025 rsp_q/flags SHALL hold their last value until the next RESP.
REQ-026 div_valid outside WAIT SHALL be ignored.
REQ-027 req_valid changes outside IDLE SHALL be ignored, and requests SHALL stay pending until accepted.
REQ-028 Latency: accept at cycle T, div_start at T+1, rsp_valid one cycle after div_valid; back-to-back minimum spacing between accepts is 4 cycles.
REQ-029 The wait counter SHALL be $clog2(TIMEOUT) bits wide, with no wrap beyond TIMEOUT-1.

Reset
REQ-030 While sclr=1 the state SHALL be IDLE, p=0, and all outputs 0 (req_ready, rsp_valid, rsp_q, flags, div_start, div_a, div_b).
REQ-031 sclr asserted mid-operation SHALL abandon the transaction with no response pulse; the Divider shares sclr.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE/ISSUE/WAIT/RESP) and the default W/N_REQ/TIMEOUT constants.
REQ-033 A sub-module rr_arbiter (req vector, pointer -> one-hot grant plus index, combinational) SHALL be instantiated once.

Verification
REQ-034 Stub Divider with 12-cycle latency, q=0x0A0. req0 a=0x050 b=0x020 -> req_ready=0001 at T, div_start at T+1, rsp_valid=0001 with rsp_q=0x0A0 at T+14.
REQ-035 req_valid=1111 held continuously -> grants in order 0,1,2,3,0, each followed by exactly one matching rsp_valid.
REQ-036 Stub returns dvz=1 for b=0 on req2 -> rsp_valid=0100, rsp_dvz=1, rsp_ovf=0, rsp_tmo=0.
REQ-037 Stub never asserts div_valid -> rsp_tmo=1 and rsp_q=0 exactly TIMEOUT cycles after div_start, then the next request is granted normally.
REQ-038 div_busy=1 with req_valid=0010 -> no req_ready until div_busy falls.
REQ-039 sclr pulsed during WAIT -> no rsp_valid, all outputs 0, and the next request is granted to requester 0 first.
